seq_multiplier_param: RTL and testbench

//   Parametrised iterative shift-add multiplier, one partial product per clock.

---
 rtl/seq_multiplier_param.sv | 128 ++++++++++++
 tb/tb_seq_multiplier_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_param.sv
// Iterative shift-add multiplier: one partial product per clock, optional
// two's-complement operands, ready/done handshake with back-to-back issue.
module seq_multiplier_param #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StSign,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     p_q, p_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              neg_q, neg_d;

  logic [WIDTH-1:0]  mag_a, mag_b;

  // Negating the most negative value wraps to the same bit pattern, which
  // read as unsigned is exactly its magnitude.
  always_comb begin
    mag_a = a;
    mag_b = b;
    if (is_signed && a[WIDTH-1]) begin
      mag_a = ~a + WIDTH'(1);
    end
    if (is_signed && b[WIDTH-1]) begin
      mag_b = ~b + WIDTH'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    p_d      = p_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StBusy;
          acc_d    = '0;
          mcand_d  = PW'(mag_a);
          mplier_d = mag_b;
          count_d  = '0;
          neg_d    = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end

      StBusy: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (count_q == LastCnt) begin
          count_d = '0;
          state_d = StSign;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      StSign: begin
        // Two's-complement negation of zero is zero, so no special case.
        p_d     = neg_q ? -acc_q : acc_q;
        state_d = StDone;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
    end
  end

  always_comb begin
    ready = (state_q == StIdle) || (state_q == StDone);
    busy  = (state_q == StBusy) || (state_q == StSign);
    done  = (state_q == StDone);
    p     = p_q;
  end

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Directed bench for seq_multiplier_param: a 32-bit instance for the main
// vectors and an 8-bit instance for the narrow-width run.
module tb_seq_multiplier_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        s_start = 1'b0, s_sgn = 1'b0;
  logic [31:0] s_a = '0, s_b = '0;
  logic        r32, bz32, dn32;
  logic [63:0] p32;

  logic        e_start = 1'b0, e_sgn = 1'b0;
  logic [7:0]  e_a = '0, e_b = '0;
  logic        r8, bz8, dn8;
  logic [15:0] p8;

  int checks = 0;
  int failures = 0;

  seq_multiplier_param #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .is_signed(s_sgn),
    .a(s_a), .b(s_b), .ready(r32), .busy(bz32), .done(dn32), .p(p32)
  );

  seq_multiplier_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(e_start), .is_signed(e_sgn),
    .a(e_a), .b(e_b), .ready(r8), .busy(bz8), .done(dn8), .p(p8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until done (bounded); reports clocks waited and whether ready stayed low.
  task automatic wait_done32(output int n, output bit rl);
    n  = 0;
    rl = 1'b1;
    while (!dn32 && n < 200) begin
      if (r32) rl = 1'b0;
      tick();
      n++;
    end
  endtask

  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic [63:0] exp);
    int n;
    bit rl;
    s_a = a; s_b = b; s_sgn = sgn; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    wait_done32(n, rl);
    check({tag, "_lat"}, 64'(n), 64'd33);
    check({tag, "_p"}, p32, exp);
    tick();
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sgn, input logic [15:0] exp);
    int n;
    e_a = a; e_b = b; e_sgn = sgn; e_start = 1'b1;
    tick();
    e_start = 1'b0;
    n = 0;
    while (!dn8 && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd9);
    check({tag, "_p"}, 64'(p8), 64'(exp));
    tick();
  endtask

  initial begin
    int  n, n2;
    bit  rl;
    bit  saw_done;

    // Reset values
    tick();
    tick();
    check("rst_ready", 64'(r32), 64'd1);
    check("rst_busy", 64'(bz32), 64'd0);
    check("rst_done", 64'(dn32), 64'd0);
    check("rst_p", p32, 64'd0);
    check("rst_p8", 64'(p8), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1) unsigned 351*23 with latency and ready-low check
    s_a = 32'd351; s_b = 32'd23; s_sgn = 1'b0; s_start = 1'b1;
    check("t1_ready_idle", 64'(r32), 64'd1);
    tick();
    s_start = 1'b0;
    check("t1_busy", 64'(bz32), 64'd1);
    check("t1_p_held", p32, 64'd0);
    wait_done32(n, rl);
    check("t1_lat", 64'(n), 64'd33);
    check("t1_ready_low", 64'(rl), 64'd1);
    check("t1_p", p32, 64'h1F89);
    check("t1_ready_done", 64'(r32), 64'd1);
    tick();
    check("t1_done_pulse", 64'(dn32), 64'd0);
    check("t1_p_stable", p32, 64'h1F89);

    // 2) back-to-back: start held high the whole time
    s_a = 32'd7; s_b = 32'd6; s_sgn = 1'b0; s_start = 1'b1;
    tick();
    s_a = 32'd10; s_b = 32'd32;
    wait_done32(n, rl);
    check("t2_lat1", 64'(n), 64'd33);
    check("t2_p1", p32, 64'd42);
    tick();
    s_start = 1'b0;
    check("t2_rearm_done", 64'(dn32), 64'd0);
    check("t2_rearm_busy", 64'(bz32), 64'd1);
    wait_done32(n2, rl);
    check("t2_acc_to_acc", 64'(n + 1), 64'd34);
    check("t2_lat2", 64'(n2), 64'd33);
    check("t2_p2", p32, 64'h140);
    tick();
    check("t2_done_drop", 64'(dn32), 64'd0);

    // 3) signed vectors
    run32("t3_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
    run32("t3_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run32("t3_m7x0", 32'hFFFF_FFF9, 32'd0, 1'b1, 64'd0);
    run32("t3_m6x7", 32'hFFFF_FFFA, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);

    // 4) all-ones both ways
    run32("t4_uns", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run32("t4_sgn", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h1);

    // 5) start pulse and operand change mid-operation are ignored
    s_a = 32'd1000; s_b = 32'd3; s_sgn = 1'b0; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    s_a = 32'd5; s_b = 32'hFFFF_FFFF; s_sgn = 1'b1; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    wait_done32(n, rl);
    check("t5_lat", 64'(n + 6), 64'd33);
    check("t5_p", p32, 64'hBB8);
    tick();
    check("t5_no_requeue", 64'(bz32), 64'd0);

    // 6) async reset at BUSY cycle 10
    s_a = 32'd9; s_b = 32'd9; s_sgn = 1'b0; s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 64'(r32), 64'd1);
    check("t6_rst_busy", 64'(bz32), 64'd0);
    check("t6_rst_p", p32, 64'd0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dn32) saw_done = 1'b1;
    end
    check("t6_no_done", 64'(saw_done), 64'd0);
    run32("t6_after", 32'd12, 32'd12, 1'b0, 64'h90);

    // WIDTH=8 instance
    run8("w8_200x200", 8'd200, 8'd200, 1'b0, 16'h9C40);
    run8("w8_minxmin", 8'h80, 8'h80, 1'b1, 16'h4000);
    run8("w8_m1x1", 8'hFF, 8'h01, 1'b1, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
